regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with write-to-read bypass and a busy-bit scoreboard.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 53 +++++
 rtl/regfile_mp_sb.sv | 84 ++++++++
 tb/tb_regfile_mp_sb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned REG_ZERO  = 0;

  function automatic int unsigned addr_w(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, writeback clears it, flush clears all.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned AW     = addr_w(NREGS),
  parameter int unsigned CW     = cnt_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy,
  output logic [CW-1:0]        pend_cnt
);

  logic [NREGS-1:0] busy_d, busy_q;
  logic [CW-1:0]    cnt_d, cnt_q;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      // Issue applied last: a new producer outranks a same-cycle writeback.
      if (iss_en) busy_d[iss_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
    cnt_d = '0;
    for (int r = 1; r < NREGS; r++) cnt_d = cnt_d + CW'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with x0 hardwired to zero, optional writeback bypass and busy scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = addr_w(NREGS),
  localparam int unsigned CW    = cnt_w(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   flush,
  output logic [CW-1:0]          pend_cnt
);

  logic [XLEN-1:0]  mem_d [NREGS];
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy;

  reg_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR),
    .AW     (AW),
    .CW     (CW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .busy     (busy),
    .pend_cnt (pend_cnt)
  );

  // Ascending port order so the highest-index writer lands last and wins.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) mem_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end
    mem_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*AW +: AW] != AW'(REG_ZERO)) begin
        rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
        rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW]) begin
              rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
              rd_busy[k]              = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Drives a bypassing 32x2R and a non-bypassing 16x3R instance with identical stimulus.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra [3];
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;

  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [5:0]  a_pend;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic [4:0]  b_pend;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  int checks = 0;
  int errors = 0;

  regfile_mp_sb #(
    .XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)
  ) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  ({ra[1], ra[0]}),
    .rd_data  (a_rd_data),
    .rd_busy  (a_rd_busy),
    .wr_en    (we),
    .wr_addr  ({wa[1], wa[0]}),
    .wr_data  ({wd[1], wd[0]}),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .pend_cnt (a_pend)
  );

  regfile_mp_sb #(
    .XLEN(32), .NREGS(16), .NUM_RD(3), .NUM_WR(2), .BYPASS(0)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  ({ra[2][3:0], ra[1][3:0], ra[0][3:0]}),
    .rd_data  (b_rd_data),
    .rd_busy  (b_rd_busy),
    .wr_en    (we),
    .wr_addr  ({wa[1][3:0], wa[0][3:0]}),
    .wr_data  ({wd[1], wd[0]}),
    .iss_en   (iss_en),
    .iss_addr (iss_addr[3:0]),
    .flush    (flush),
    .pend_cnt (b_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pend();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // Returns {busy, data} for a read of addr, with or without forwarding.
  function automatic logic [32:0] ref_read(input logic [4:0] addr, input bit byp);
    logic [32:0] res;
    if (addr == 0) return 33'h0;
    res = {m_busy[addr] ? 1'b1 : 1'b0, m_mem[addr]};
    if (byp) begin
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j] == addr) res = {1'b0, wd[j]};
    end
    return res;
  endfunction

  task automatic check_model();
    logic [32:0] e;
    for (int k = 0; k < 2; k++) begin
      e = ref_read(ra[k], 1'b1);
      chk($sformatf("a_data%0d", k), {32'h0, a_rd_data[k*32 +: 32]}, {32'h0, e[31:0]});
      chk($sformatf("a_busy%0d", k), {63'h0, a_rd_busy[k]}, {63'h0, e[32]});
    end
    for (int k = 0; k < 3; k++) begin
      e = ref_read(ra[k], 1'b0);
      chk($sformatf("b_data%0d", k), {32'h0, b_rd_data[k*32 +: 32]}, {32'h0, e[31:0]});
      chk($sformatf("b_busy%0d", k), {63'h0, b_rd_busy[k]}, {63'h0, e[32]});
    end
    chk("a_pend", {58'h0, a_pend}, 64'(model_pend()));
    chk("b_pend", {59'h0, b_pend}, 64'(model_pend()));
  endtask

  task automatic model_update();
    bit wrote [32];
    for (int r = 0; r < 32; r++) wrote[r] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (we[j] && wa[j] != 0) begin
        m_mem[wa[j]] = wd[j];
        wrote[wa[j]] = 1'b1;
      end
    end
    for (int r = 1; r < 32; r++) begin
      if (flush) m_busy[r] = 1'b0;
      else if (iss_en && iss_addr == 5'(r)) m_busy[r] = 1'b1;
      else if (wrote[r]) m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = 32'h0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    we = 2'b00; iss_en = 1'b0; flush = 1'b0; iss_addr = 5'd0;
    wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'h0; wd[1] = 32'h0;
  endtask

  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd3;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Write x5, read it next cycle.
    we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5;
    #1 chk("byp_x5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
    tick();
    idle();
    #1 chk("rd_x5", {32'h0, b_rd_data[31:0]}, 64'hDEADBEEF);
    tick();

    // x0 ignores writes.
    we = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1; ra[0] = 5'd0;
    tick();
    idle();
    #1 chk("rd_x0", {32'h0, a_rd_data[31:0]}, 64'h0);
    tick();

    // Two writers to x7: port 1 wins, also on the bypass path.
    we = 2'b11; wa[0] = 5'd7; wd[0] = 32'h11; wa[1] = 5'd7; wd[1] = 32'h22; ra[1] = 5'd7;
    #1 chk("byp_x7", {32'h0, a_rd_data[63:32]}, 64'h22);
    tick();
    idle();
    #1 chk("rd_x7", {32'h0, b_rd_data[63:32]}, 64'h22);
    tick();

    // Issue x3, then writeback with same-cycle read.
    iss_en = 1'b1; iss_addr = 5'd3; ra[0] = 5'd3;
    tick();
    idle();
    #1 chk("busy_x3", {63'h0, a_rd_busy[0]}, 64'h1);
    chk("pend_1", {58'h0, a_pend}, 64'h1);
    tick();
    we = 2'b01; wa[0] = 5'd3; wd[0] = 32'h55;
    #1 chk("byp_x3", {32'h0, a_rd_data[31:0]}, 64'h55);
    chk("byp_busy_x3", {63'h0, a_rd_busy[0]}, 64'h0);
    chk("nobyp_busy_x3", {63'h0, b_rd_busy[0]}, 64'h1);
    tick();
    idle();
    #1 chk("clr_x3", {63'h0, b_rd_busy[0]}, 64'h0);
    chk("pend_0", {59'h0, b_pend}, 64'h0);
    tick();

    // Issue and writeback of x4 together: stays busy, data lands.
    iss_en = 1'b1; iss_addr = 5'd4; we = 2'b10; wa[1] = 5'd4; wd[1] = 32'h66; ra[2] = 5'd4;
    tick();
    idle();
    #1 chk("busy_x4", {63'h0, b_rd_busy[2]}, 64'h1);
    chk("data_x4", {32'h0, b_rd_data[95:64]}, 64'h66);
    chk("pend_x4", {58'h0, a_pend}, 64'h1);
    we = 2'b01; wa[0] = 5'd4; wd[0] = 32'h66;
    tick();

    // Issue x1, x2, x9 then flush; contents untouched.
    idle(); iss_en = 1'b1; iss_addr = 5'd1; tick();
    iss_addr = 5'd2; tick();
    iss_addr = 5'd9; tick();
    idle();
    #1 chk("pend_3", {58'h0, a_pend}, 64'h3);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle(); ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd6;
    #1 chk("flush_pend", {59'h0, b_pend}, 64'h0);
    chk("flush_x5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
    chk("flush_iss6", {63'h0, b_rd_busy[2]}, 64'h0);
    tick();

    // Randomised traffic over the shared 16-register window.
    for (int i = 0; i < 400; i++) begin
      we       = 2'($urandom);
      wa[0]    = 5'($urandom_range(0, 15));
      wa[1]    = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom_range(0, 15));
      wd[0]    = $urandom;
      wd[1]    = $urandom;
      iss_en   = ($urandom_range(0, 2) != 0);
      iss_addr = 5'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < 3; k++)
        ra[k] = ($urandom_range(0, 2) == 0) ? wa[k % 2] : 5'($urandom_range(0, 15));
      tick();
    end

    // Asynchronous reset mid-cycle with a write pending.
    idle(); we = 2'b01; wa[0] = 5'd6; wd[0] = 32'hABCD; iss_en = 1'b1; iss_addr = 5'd6;
    ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd6;
    #2 rst_n = 1'b0;
    #1 idle();
    model_reset();
    #1 check_model();
    chk("rst_x5", {32'h0, a_rd_data[31:0]}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_x6_lost", {32'h0, b_rd_data[95:64]}, 64'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
